// File: rtl/gate_request_arbiter.sv
// Gate request arbiter: synchronizes and debounces the entry/exit car sensors, latches requests
// and issues single-cycle pulses to the parking FSM. Define GATE_DEBOUNCE_EN for debounce logic.
module gate_request_arbiter #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLDOFF_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       entry_sensor,
    input  logic       exit_sensor,
    input  logic [1:0] exit_sel,
    output logic       entry_signal,
    output logic       exit_signal,
    output logic [1:0] exit_slot,
    output logic       entry_pending,
    output logic       exit_pending,
    output logic       dropped
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be in 1..15");
    end
    if (HOLDOFF_CYCLES > 15) begin : g_bad_holdoff
        $error("HOLDOFF_CYCLES must be in 0..15");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StHold} state_e;

    localparam logic [3:0] HoldLast = 4'(HOLDOFF_CYCLES - 1);

    // Lane index 0 is entry, 1 is exit.
    logic [1:0] sync1_q, sync2_q, level, level_prev_q, rise;
    logic       entry_pend_q, entry_pend_d, exit_pend_q, exit_pend_d;
    logic       entry_sig_q, entry_sig_d, exit_sig_q, exit_sig_d;
    logic       drop_q, drop_d, clr_entry, clr_exit;
    logic [1:0] slot_q, slot_d, exit_slot_q, exit_slot_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    state_e     state_q, state_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= {exit_sensor, entry_sensor};
            sync2_q <= sync1_q;
        end
    end

`ifdef GATE_DEBOUNCE_EN
    localparam logic [3:0] DebLast = 4'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      level_q, level_d;
    logic [1:0][3:0] deb_cnt_q, deb_cnt_d;

    // A new level is accepted after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        level_d   = level_q;
        deb_cnt_d = deb_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == level_q[i]) begin
                deb_cnt_d[i] = 4'd0;
            end else if (deb_cnt_q[i] == DebLast) begin
                level_d[i]   = sync2_q[i];
                deb_cnt_d[i] = 4'd0;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q   <= 2'b00;
            deb_cnt_q <= '0;
        end else begin
            level_q   <= level_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign level = level_q;
`else
    assign level = sync2_q;
`endif

    assign rise = level & ~level_prev_q;

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        entry_sig_d = 1'b0;
        exit_sig_d  = 1'b0;
        exit_slot_d = exit_slot_q;
        clr_entry   = 1'b0;
        clr_exit    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (exit_pend_q) begin
                    state_d     = StIssue;
                    exit_sig_d  = 1'b1;
                    exit_slot_d = slot_q;
                    clr_exit    = 1'b1;
                end else if (entry_pend_q) begin
                    state_d     = StIssue;
                    entry_sig_d = 1'b1;
                    clr_entry   = 1'b1;
                end
            end
            StIssue: begin
                hold_cnt_d = 4'd0;
                state_d    = (HOLDOFF_CYCLES > 0) ? StHold : StIdle;
            end
            StHold: begin
                if (hold_cnt_q == HoldLast) begin
                    state_d    = StIdle;
                    hold_cnt_d = 4'd0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A fresh request beats a same-edge clear; it only merges if the flag stays set.
    always_comb begin
        entry_pend_d = (entry_pend_q & ~clr_entry) | rise[0];
        exit_pend_d  = (exit_pend_q & ~clr_exit) | rise[1];
        drop_d       = (rise[0] & entry_pend_q & ~clr_entry) |
                       (rise[1] & exit_pend_q & ~clr_exit);
        slot_d       = (rise[1] && !(exit_pend_q && !clr_exit)) ? exit_sel : slot_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_prev_q <= 2'b00;
            entry_pend_q <= 1'b0;
            exit_pend_q  <= 1'b0;
            entry_sig_q  <= 1'b0;
            exit_sig_q   <= 1'b0;
            drop_q       <= 1'b0;
            slot_q       <= 2'b00;
            exit_slot_q  <= 2'b00;
            hold_cnt_q   <= 4'd0;
            state_q      <= StIdle;
        end else begin
            level_prev_q <= level;
            entry_pend_q <= entry_pend_d;
            exit_pend_q  <= exit_pend_d;
            entry_sig_q  <= entry_sig_d;
            exit_sig_q   <= exit_sig_d;
            drop_q       <= drop_d;
            slot_q       <= slot_d;
            exit_slot_q  <= exit_slot_d;
            hold_cnt_q   <= hold_cnt_d;
            state_q      <= state_d;
        end
    end

    assign entry_signal  = entry_sig_q;
    assign exit_signal   = exit_sig_q;
    assign exit_slot     = exit_slot_q;
    assign entry_pending = entry_pend_q;
    assign exit_pending  = exit_pend_q;
    assign dropped       = drop_q;

endmodule

// File: tb/tb_gate_request_arbiter.sv
// Directed self-checking bench for gate_request_arbiter; expectations follow GATE_DEBOUNCE_EN.
module tb_gate_request_arbiter;

    localparam int D  = 4;
    localparam int H  = 2;
    localparam int HM = 15;
`ifdef GATE_DEBOUNCE_EN
    localparam int LAT           = D + 4;
    localparam int GLITCH_PULSES = 0;
`else
    localparam int LAT           = 4;
    localparam int GLITCH_PULSES = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       entry_sensor = 1'b0, exit_sensor = 1'b0;
    logic [1:0] exit_sel = 2'b00;
    logic       entry_signal, exit_signal, entry_pending, exit_pending, dropped;
    logic [1:0] exit_slot;
    logic       m_entry = 1'b0, m_exit = 1'b0;
    logic [1:0] m_sel = 2'b00;
    logic       m_entry_signal, m_exit_signal, m_entry_pending, m_exit_pending, m_dropped;
    logic [1:0] m_exit_slot;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gate_request_arbiter #(.DEBOUNCE_CYCLES(D), .HOLDOFF_CYCLES(H)) dut (
        .clk(clk), .reset(reset), .entry_sensor(entry_sensor), .exit_sensor(exit_sensor),
        .exit_sel(exit_sel), .entry_signal(entry_signal), .exit_signal(exit_signal),
        .exit_slot(exit_slot), .entry_pending(entry_pending), .exit_pending(exit_pending),
        .dropped(dropped)
    );

    gate_request_arbiter #(.DEBOUNCE_CYCLES(D), .HOLDOFF_CYCLES(HM)) dut_m (
        .clk(clk), .reset(reset), .entry_sensor(m_entry), .exit_sensor(m_exit),
        .exit_sel(m_sel), .entry_signal(m_entry_signal), .exit_signal(m_exit_signal),
        .exit_slot(m_exit_slot), .entry_pending(m_entry_pending),
        .exit_pending(m_exit_pending), .dropped(m_dropped)
    );

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        entry_sensor = 1'b1; exit_sensor = 1'b1; exit_sel = 2'b11;
        m_entry = 1'b1; m_exit = 1'b1; m_sel = 2'b11;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({entry_signal, exit_signal, exit_slot, entry_pending, exit_pending, dropped} !== 7'b0)
        begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {entry_signal, exit_signal, exit_slot, entry_pending, exit_pending, dropped});
        end
        checks++;
        if ({m_entry_signal, m_exit_signal, m_exit_slot, m_entry_pending, m_exit_pending,
             m_dropped} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs_m: got %b expected 0000000",
                     {m_entry_signal, m_exit_signal, m_exit_slot, m_entry_pending,
                      m_exit_pending, m_dropped});
        end
        entry_sensor = 1'b0; exit_sensor = 1'b0; exit_sel = 2'b00;
        m_entry = 1'b0; m_exit = 1'b0; m_sel = 2'b00;
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if ({entry_pending, exit_pending, entry_signal, exit_signal} !== 4'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got %b expected 0000",
                     {entry_pending, exit_pending, entry_signal, exit_signal});
        end
    endtask

    task automatic test_entry_latency();
        int pulses;
        do_reset();
        @(posedge clk); #1;
        entry_sensor = 1'b1;
        for (int e = 1; e <= LAT + 3; e++) begin
            @(posedge clk); #1;
            checks++;
            if ({entry_pending, entry_signal, exit_signal} !== {e == LAT - 1, e == LAT, 1'b0})
            begin
                errors++;
                $display("FAIL entry_latency edge %0d: got pend/ent/exit %b expected %b", e,
                         {entry_pending, entry_signal, exit_signal},
                         {e == LAT - 1, e == LAT, 1'b0});
            end
        end
        entry_sensor = 1'b0;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (entry_signal || entry_pending) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL falling_edge_no_request: got %0d active cycles expected 0", pulses);
        end
    endtask

    task automatic test_glitch();
        int pulses, pend;
        do_reset();
        @(posedge clk); #1;
        entry_sensor = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        entry_sensor = 1'b0;
        pulses = 0; pend = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (entry_signal) pulses++;
            if (entry_pending) pend++;
        end
        checks++;
        if (pulses !== GLITCH_PULSES) begin
            errors++;
            $display("FAIL glitch_pulses: got %0d expected %0d", pulses, GLITCH_PULSES);
        end
        checks++;
        if (pend !== GLITCH_PULSES) begin
            errors++;
            $display("FAIL glitch_pending: got %0d cycles expected %0d", pend, GLITCH_PULSES);
        end
    endtask

    task automatic test_simultaneous();
        int exit_idx, entry_idx, exit_cnt, entry_cnt, both;
        logic [1:0] slot_at_pulse;
        do_reset();
        exit_idx = -1; entry_idx = -1; exit_cnt = 0; entry_cnt = 0; both = 0;
        slot_at_pulse = 2'b00;
        @(posedge clk); #1;
        entry_sensor = 1'b1; exit_sensor = 1'b1; exit_sel = 2'b10;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (entry_signal && exit_signal) both++;
            if (exit_signal) begin
                exit_cnt++;
                if (exit_idx < 0) begin exit_idx = e; slot_at_pulse = exit_slot; end
            end
            if (entry_signal) begin
                entry_cnt++;
                if (entry_idx < 0) entry_idx = e;
            end
            if (e == LAT - 1) exit_sel = 2'b01;
        end
        checks++;
        if (exit_idx !== LAT) begin
            errors++;
            $display("FAIL sim_exit_edge: got %0d expected %0d", exit_idx, LAT);
        end
        checks++;
        if (slot_at_pulse !== 2'b10) begin
            errors++;
            $display("FAIL sim_exit_slot: got %b expected 10", slot_at_pulse);
        end
        checks++;
        if (entry_idx !== LAT + H + 2) begin
            errors++;
            $display("FAIL sim_entry_edge: got %0d expected %0d", entry_idx, LAT + H + 2);
        end
        checks++;
        if (both !== 0) begin
            errors++;
            $display("FAIL sim_both_high: got %0d cycles expected 0", both);
        end
        checks++;
        if ({exit_cnt, entry_cnt} !== {32'd1, 32'd1}) begin
            errors++;
            $display("FAIL sim_pulse_counts: got exit %0d entry %0d expected 1 1",
                     exit_cnt, entry_cnt);
        end
        checks++;
        if (exit_slot !== 2'b10) begin
            errors++;
            $display("FAIL sim_slot_hold: got %b expected 10", exit_slot);
        end
        entry_sensor = 1'b0; exit_sensor = 1'b0; exit_sel = 2'b00;
    endtask

    task automatic test_merge();
        int exit_idx, entry_idx, exit_cnt, entry_cnt, drop_cnt;
        do_reset();
        exit_idx = -1; entry_idx = -1; exit_cnt = 0; entry_cnt = 0; drop_cnt = 0;
        @(posedge clk); #1;
        m_entry = 1'b1; m_exit = 1'b1; m_sel = 2'b01;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk); #1;
            if (m_exit_signal) begin exit_cnt++; if (exit_idx < 0) exit_idx = e; end
            if (m_entry_signal) begin entry_cnt++; if (entry_idx < 0) entry_idx = e; end
            if (m_dropped) drop_cnt++;
            if (e == 8) m_entry = 1'b0;
            if (e == 16) m_entry = 1'b1;
        end
        checks++;
        if (entry_cnt !== 1) begin
            errors++;
            $display("FAIL merge_entry_count: got %0d expected 1", entry_cnt);
        end
        checks++;
        if (drop_cnt !== 1) begin
            errors++;
            $display("FAIL merge_dropped_count: got %0d expected 1", drop_cnt);
        end
        checks++;
        if (exit_cnt !== 1 || exit_idx !== LAT) begin
            errors++;
            $display("FAIL merge_exit: got count %0d edge %0d expected 1 %0d",
                     exit_cnt, exit_idx, LAT);
        end
        checks++;
        if (entry_idx !== LAT + HM + 2) begin
            errors++;
            $display("FAIL merge_entry_edge: got %0d expected %0d", entry_idx, LAT + HM + 2);
        end
        checks++;
        if (m_exit_slot !== 2'b01) begin
            errors++;
            $display("FAIL merge_exit_slot: got %b expected 01", m_exit_slot);
        end
        m_entry = 1'b0; m_exit = 1'b0; m_sel = 2'b00;
    endtask

    task automatic test_reset_mid_hold();
        int active;
        do_reset();
        @(posedge clk); #1;
        m_entry = 1'b1;
        for (int e = 1; e <= LAT + 6; e++) begin
            @(posedge clk); #1;
            if (e == 3) begin m_exit = 1'b1; m_sel = 2'b11; end
        end
        checks++;
        if ({m_exit_pending, m_entry_pending} !== 2'b10) begin
            errors++;
            $display("FAIL midhold_pending: got exit/entry %b expected 10",
                     {m_exit_pending, m_entry_pending});
        end
        reset = 1'b0;
        #2;
        checks++;
        if ({m_entry_signal, m_exit_signal, m_exit_slot, m_entry_pending, m_exit_pending,
             m_dropped} !== 7'b0) begin
            errors++;
            $display("FAIL midhold_reset_outputs: got %b expected 0000000",
                     {m_entry_signal, m_exit_signal, m_exit_slot, m_entry_pending,
                      m_exit_pending, m_dropped});
        end
        m_entry = 1'b0; m_exit = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        active = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (m_exit_signal || m_entry_signal || m_exit_pending || m_entry_pending) active++;
        end
        checks++;
        if (active !== 0) begin
            errors++;
            $display("FAIL midhold_after_release: got %0d active cycles expected 0", active);
        end
    endtask

    task automatic test_hold_through_reset();
        int idx, cnt;
        idx = -1; cnt = 0;
        entry_sensor = 1'b1;
        do_reset();
        for (int e = 1; e <= LAT + 20; e++) begin
            @(posedge clk); #1;
            if (entry_signal) begin cnt++; if (idx < 0) idx = e; end
        end
        checks++;
        if (cnt !== 1) begin
            errors++;
            $display("FAIL through_reset_count: got %0d expected 1", cnt);
        end
        checks++;
        if (idx !== LAT) begin
            errors++;
            $display("FAIL through_reset_edge: got %0d expected %0d", idx, LAT);
        end
        entry_sensor = 1'b0;
    endtask

    initial begin
        test_reset();
        test_entry_latency();
        test_glitch();
        test_simultaneous();
        test_merge();
        test_reset_mid_hold();
        test_hold_through_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_request_arbiter.md
GATE_REQUEST_ARBITER -- requirements
Module: gate_request_arbiter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, meaning consecutive equal synchronized samples needed before a sensor level is accepted (range 1-15).
REQ-002 Parameter HOLDOFF_CYCLES, default 2, meaning idle cycles forced after each issued pulse (range 0-15).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  one clock; reset is asynchronous and active-low.
REQ-005 entry_sensor  input  1  raw asynchronous entry-lane car detector, high = car present.
REQ-006 exit_sensor  input  1  raw asynchronous exit-lane car detector, high = car present.
REQ-007 exit_sel  input  2  slot of the exiting car, synchronous to clk.
REQ-008 entry_signal  output  1  registered single-cycle entry request to the parking FSM.
REQ-009 exit_signal  output  1  registered single-cycle exit request to the parking FSM.
REQ-010 exit_slot  output  2  registered slot accompanying exit_signal.
REQ-011 entry_pending  output  1  entry request latched, not yet issued.
REQ-012 exit_pending  output  1  exit request latched, not yet issued.
REQ-013 dropped  output  1  single-cycle pulse when a new request merges into an already pending one.

Function
REQ-014 Each sensor SHALL pass through a 2-flop synchronizer before any other logic.
REQ-015 A rising edge of the accepted (debounced) level SHALL set the lane's pending flag one edge later; falling edges SHALL create no request.
REQ-016 On an exit request, exit_sel SHALL be captured into an internal slot register on the same edge that sets exit_pending.
REQ-017 A new request on a lane whose pending flag is already set SHALL leave the flag set, keep the originally captured slot, and pulse dropped for one cycle.
REQ-018 Arbiter states: IDLE, ISSUE, HOLD; IDLE -> ISSUE when any pending flag is set; ISSUE -> HOLD if HOLDOFF_CYCLES > 0, else ISSUE -> IDLE; HOLD -> IDLE after exactly HOLDOFF_CYCLES cycles.
REQ-019 On the IDLE -> ISSUE transition edge exactly one pulse output SHALL go high for exactly one cycle, and the served pending flag SHALL clear on that edge.
REQ-020 When both flags are set in IDLE, exit SHALL be served first; entry is served on the next IDLE.
REQ-021 exit_slot SHALL carry the captured slot during the exit_signal cycle and hold its last value otherwise.
REQ-022 entry_signal and exit_signal SHALL never be high in the same cycle.
REQ-023 Requests arriving during ISSUE or HOLD SHALL be latched and served on the next IDLE.
REQ-024 A lane request and its own pending-clear on the same edge SHALL leave the flag set (new request wins).
REQ-025 Latency: raw sensor high sampled at edge 1 -> pulse high in the cycle after edge DEBOUNCE_CYCLES+4 when the arbiter is IDLE.

Reset
REQ-026 While reset is low: all outputs 0, exit_slot 2'b00, pending flags 0, synchronizers and debounced levels 0, debounce and holdoff counters 0, arbiter IDLE.
REQ-027 Reset asserted mid-operation SHALL discard all pending requests and any pulse in flight.
REQ-028 A sensor held high through reset release SHALL produce exactly one request once debounced.

Configuration
REQ-029 Macro GATE_DEBOUNCE_EN defined: debounce counters per REQ-001 are compiled in.
REQ-030 Macro GATE_DEBOUNCE_EN undefined: debounce logic is compiled out, the accepted level is the synchronizer output, DEBOUNCE_CYCLES is ignored, and latency is pulse after edge 4.

Verification
REQ-031 Entry: reset, entry_sensor high from edge 1, macro on, D=4 -> entry_signal high exactly one cycle after edge 8, entry_pending high the cycle before.
REQ-032 Glitch: entry_sensor high for 2 cycles then low, D=4 -> no entry_signal, no pending.
REQ-033 Simultaneous: both sensors rise same cycle, exit_sel=2'b10, H=2 -> exit_signal with exit_slot=2'b10, then entry_signal exactly 4 cycles later.
REQ-034 Merge: two debounced entry edges before service -> one entry_signal, dropped pulses once.
REQ-035 Reset mid-HOLD with exit_pending set -> all outputs 0; after release no exit_signal unless exit_sensor re-rises.
REQ-036 Macro off: exit_sensor high from edge 1, exit_sel=2'b11 -> exit_signal with exit_slot=2'b11 in the cycle after edge 4.
